// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Blinks an LED a programmable number of times. A command gives the blink
// count, the on-time and the off-time. Times are counted in ticks, and one
// tick is CLK_DIV clock cycles. A count of 0 blinks until aborted.
//
// Ports
//   clock      in   single clock; all state changes on its rising edge
//   reset_n    in   synchronous, active-low reset
//   cmd_valid  in   a blink command is presented
//   cmd_ready  out  the sequencer can accept a command (idle, no abort)
//   cmd_count  in   number of blinks, 0 = continuous
//   cmd_on     in   LED-on duration in ticks (0 is treated as 1)
//   cmd_off    in   LED-off duration in ticks (0 is treated as 1)
//   abort      in   terminate the active sequence
//   led        out  registered LED drive, high only in the ON state
//   busy       out  a sequence is active
//   done       out  one-cycle pulse in the first idle cycle after a sequence
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int TIME_W  = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [TIME_W-1:0]  cmd_on,
  input  logic [TIME_W-1:0]  cmd_off,
  input  logic               abort,
  output logic               led,
  output logic               busy,
  output logic               done
);

  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               finish;
  logic [PRE_W-1:0]   presc;
  logic [TIME_W-1:0]  tcnt;      // ticks left in the current phase, never 0 while active
  logic [TIME_W-1:0]  on_len;
  logic [TIME_W-1:0]  off_len;
  logic [COUNT_W-1:0] blinks;    // blinks left; 0 means continuous

  logic accept;
  logic tick;
  logic phase_end;

  // A zero duration would otherwise underflow the phase counter.
  function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] t);
    return (t == '0) ? TIME_W'(1) : t;
  endfunction

  // Gated by reset_n so the handshake stays closed while reset is asserted.
  assign cmd_ready = reset_n && (state == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (presc == PRE_LAST);
  assign phase_end = tick && (tcnt == TIME_W'(1));

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ON;
      end
      ST_ON: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end else if (phase_end) begin
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end else if (phase_end) begin
          // One blink left means this OFF phase was the last one.
          if (blinks == COUNT_W'(1)) begin
            state_nxt = ST_IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = ST_ON;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      presc   <= '0;
      tcnt    <= '0;
      on_len  <= '0;
      off_len <= '0;
      blinks  <= '0;
    end else begin
      state <= state_nxt;
      // Outputs are registered from the next state so they line up with it.
      led   <= (state_nxt == ST_ON);
      busy  <= (state_nxt != ST_IDLE);
      done  <= finish;

      // Free-running prescaler, restarted on accept so the first phase is exact.
      if (accept || tick) presc <= '0;
      else                presc <= presc + 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            on_len  <= at_least_one(cmd_on);
            off_len <= at_least_one(cmd_off);
            blinks  <= cmd_count;
            tcnt    <= at_least_one(cmd_on);
          end
        end
        ST_ON: begin
          if (tick) begin
            if (tcnt == TIME_W'(1)) tcnt <= off_len;
            else                    tcnt <= tcnt - 1'b1;
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (tcnt == TIME_W'(1)) begin
              tcnt <= on_len;
              // Continuous mode keeps blinks at 0 so it never terminates.
              if (blinks != '0) blinks <= blinks - 1'b1;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed bench for led_sequencer with CLK_DIV=4. Cycle k is the interval
// following accept edge k-1 counted from the accept edge (edge 0), so the
// first ON cycle is cycle 1. Outputs are sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_count;
  logic [7:0] cmd_on;
  logic [7:0] cmd_off;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  led_sequencer #(.CLK_DIV(CLK_DIV), .TIME_W(8), .COUNT_W(4)) dut (
    .clock    (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .cmd_on   (cmd_on),
    .cmd_off  (cmd_off),
    .abort    (abort),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int cnt, input int on, input int off);
    cmd_count = 4'(cnt);
    cmd_on    = 8'(on);
    cmd_off   = 8'(off);
    cmd_valid = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_led"},  {31'd0, led},  32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  // Checks cycles first..last of a finite sequence accepted at edge 0 and
  // leaves the bench one cycle after 'last'. Each blink is on*CLK_DIV cycles
  // of LED=1 then off*CLK_DIV cycles of LED=0; DONE follows the last blink.
  task automatic watch_finite(input string tag, input int cnt, input int on,
                              input int off, input int first, input int last);
    int on_t, off_t, period, total;
    logic e_busy, e_led, e_done;
    on_t   = (on == 0) ? 1 : on;
    off_t  = (off == 0) ? 1 : off;
    period = (on_t + off_t) * CLK_DIV;
    total  = cnt * period;
    for (int k = first; k <= last; k++) begin
      e_busy = (k >= 1) && (k <= total);
      e_led  = e_busy && (((k - 1) % period) < on_t * CLK_DIV);
      e_done = (k == total + 1);
      check($sformatf("%s_led_c%0d", tag, k),   {31'd0, led},       {31'd0, e_led});
      check($sformatf("%s_busy_c%0d", tag, k),  {31'd0, busy},      {31'd0, e_busy});
      check($sformatf("%s_done_c%0d", tag, k),  {31'd0, done},      {31'd0, e_done});
      check($sformatf("%s_ready_c%0d", tag, k), {31'd0, cmd_ready}, {31'd0, !e_busy});
      step();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_count = '0;
    cmd_on    = '0;
    cmd_off   = '0;
    abort     = 1'b0;

    // Reset: outputs low, handshake closed even though the state is idle.
    repeat (3) step();
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_idle("rst", 1'b0);
    reset_n = 1'b1;
    #1;
    check("rst_release_ready", {31'd0, cmd_ready}, 32'd1);

    // COUNT=2 ON=1 OFF=2: LED 1-4 and 13-16, BUSY 1-24, DONE at 25.
    // Inputs are scrambled after accept and must be ignored.
    present(2, 1, 2);
    step();
    cmd_valid = 1'b0;
    present(15, 7, 0);
    cmd_valid = 1'b0;
    watch_finite("seq2", 2, 1, 2, 1, 26);

    // COUNT=1 ON=0 OFF=0: zero durations behave as one tick each.
    present(1, 0, 0);
    step();
    cmd_valid = 1'b0;
    watch_finite("zero", 1, 0, 0, 1, 10);

    // ABORT in idle blocks the accept and produces no DONE.
    step();  // let the free-running prescaler drift off zero
    present(1, 1, 1);
    abort = 1'b1;
    #1;
    check("idle_abort_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check_idle("idle_abort", 1'b0);
    abort = 1'b0;
    #1;
    check("idle_abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    watch_finite("after_abort", 1, 1, 1, 1, 10);

    // Continuous ON=1 OFF=1 for 3 periods, then ABORT during cycle 25 (ON).
    present(0, 1, 1);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      check($sformatf("cont_led_c%0d", k),  {31'd0, led},  {31'd0, (((k - 1) % 8) < 4)});
      check($sformatf("cont_busy_c%0d", k), {31'd0, busy}, 32'd1);
      check($sformatf("cont_done_c%0d", k), {31'd0, done}, 32'd0);
      if (k < 25) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("cont_abort", 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      check_idle($sformatf("cont_quiet_%0d", k), 1'b0);
    end

    // Back-to-back: VALID held, second command accepted in the DONE cycle.
    present(1, 1, 1);
    step();
    present(1, 2, 1);
    watch_finite("b2b_a", 1, 1, 1, 1, 9);
    cmd_valid = 1'b0;
    watch_finite("b2b_b", 1, 2, 1, 1, 13);

    // Reset mid-ON of a COUNT=3 sequence; the old command must not resume.
    present(3, 2, 1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("rst_mid_led_on", {31'd0, led}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check_idle("rst_mid", 1'b0);
    check("rst_mid_ready_low", {31'd0, cmd_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_mid_ready_high", {31'd0, cmd_ready}, 32'd1);
    for (int k = 0; k < 30; k++) begin
      step();
      check_idle($sformatf("rst_mid_quiet_%0d", k), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
